// File: rtl/sdram_slot_arbiter.sv
// Arbitrates a ROM-load writer and two read slots onto a single-access SDRAM controller port.
// Optional abort-on-timeout for stuck accesses is enabled by defining ARB_TIMEOUT_EN.
module sdram_slot_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [7:0]        io_din,
  output logic              io_ack,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [7:0]        a_dout,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [7:0]        b_dout,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  output logic              sdram_rd,
  output logic              sdram_we,
  input  logic [7:0]        sdram_dout,
  input  logic              sdram_ready,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_IO, OWN_A, OWN_B} owner_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic              load;
  logic              capture;
  logic              abort;
  logic [ADDR_W-1:0] sel_addr;
  // last_b set means slot B was the most recent A/B grant, so A wins the next tie
  logic              last_b;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    load      = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    sel_addr  = io_addr;
    case (state)
      IDLE: begin
        if (io_req) begin
          owner_nxt = OWN_IO;
          sel_addr  = io_addr;
          load      = 1'b1;
          state_nxt = ISSUE;
        end else if (a_req && (!b_req || last_b)) begin
          owner_nxt = OWN_A;
          sel_addr  = a_addr;
          load      = 1'b1;
          state_nxt = ISSUE;
        end else if (b_req) begin
          owner_nxt = OWN_B;
          sel_addr  = b_addr;
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (sdram_ready) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IO;
      sdram_addr <= '0;
      sdram_din  <= 8'h00;
      a_dout     <= 8'hFF;
      b_dout     <= 8'hFF;
      last_b     <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (load) begin
        sdram_addr <= sel_addr;
        if (owner_nxt == OWN_IO) sdram_din <= io_din;
        else                     last_b    <= (owner_nxt == OWN_B);
      end
      // An aborted read returns all-ones to its owner, like an unprogrammed ROM byte
      if (capture || abort) begin
        if (owner == OWN_A) a_dout <= abort ? 8'hFF : sdram_dout;
        if (owner == OWN_B) b_dout <= abort ? 8'hFF : sdram_dout;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= 8'h00;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'h01;
      if (abort) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  assign sdram_rd = (state == ISSUE) && (owner != OWN_IO);
  assign sdram_we = (state == ISSUE) && (owner == OWN_IO);
  assign io_ack   = (state == DONE)  && (owner == OWN_IO);
  assign a_ack    = (state == DONE)  && (owner == OWN_A);
  assign b_ack    = (state == DONE)  && (owner == OWN_B);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter: priority, round-robin, latency, reset abort and stall behaviour.
module tb_sdram_slot_arbiter;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_req, a_req, b_req;
  logic [ADDR_W-1:0] io_addr, a_addr, b_addr;
  logic [7:0]        io_din;
  logic              io_ack, a_ack, b_ack;
  logic [7:0]        a_dout, b_dout;
  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0]        sdram_din;
  logic              sdram_rd, sdram_we;
  logic [7:0]        sdram_dout;
  logic              sdram_ready;
  logic              busy, timeout_err;

  sdram_slot_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .io_req(io_req), .io_addr(io_addr), .io_din(io_din), .io_ack(io_ack),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_dout(b_dout),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_rd(sdram_rd), .sdram_we(sdram_we),
    .sdram_dout(sdram_dout), .sdram_ready(sdram_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // SDRAM controller model: ready one pulse rsp_lat cycles after a strobe, read data from a queue
  bit         rsp_en  = 1'b1;
  int         rsp_lat = 1;
  logic [7:0] rsp_q[$];
  logic       rsp_is_rd;

  initial begin
    sdram_ready = 1'b0;
    sdram_dout  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rsp_en && (sdram_rd || sdram_we)) begin
        rsp_is_rd = sdram_rd;
        repeat (rsp_lat) begin @(posedge clk); #1; end
        sdram_dout  = (rsp_is_rd && rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
        sdram_ready = 1'b1;
        @(posedge clk); #1;
        sdram_ready = 1'b0;
      end
    end
  end

  int                log_owner[8];
  logic [7:0]        log_data[8];
  logic [7:0]        log_other[8];
  int                got, cyc, rd_cnt, we_cnt;
  logic [ADDR_W-1:0] rd_addr, we_addr;
  logic [7:0]        we_din;
  logic              seen;

  task automatic applyReset();
    reset  = 1'b1;
    io_req = 1'b0;
    a_req  = 1'b0;
    b_req  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Runs until n acks arrive (or bound cycles), logging owners, strobes and data
  task automatic applyStimulus(input int n, input bit hold, input int bound);
    got = 0; cyc = 0; rd_cnt = 0; we_cnt = 0;
    while (got < n && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
      if (sdram_we) begin we_cnt++; we_addr = sdram_addr; we_din = sdram_din; end
      if (sdram_rd) begin rd_cnt++; rd_addr = sdram_addr; end
      if (io_ack && got < 8) begin
        log_owner[got] = 0; log_data[got] = 8'h00; log_other[got] = 8'h00; got++;
        if (!hold) io_req = 1'b0;
      end
      if (a_ack && got < 8) begin
        log_owner[got] = 1; log_data[got] = a_dout; log_other[got] = b_dout; got++;
        if (!hold) a_req = 1'b0;
      end
      if (b_ack && got < 8) begin
        log_owner[got] = 2; log_data[got] = b_dout; log_other[got] = a_dout; got++;
        if (!hold) b_req = 1'b0;
      end
    end
    if (got < n) checkOutput("ack_bound", 32'(got), 32'(n));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    io_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
    io_addr = '0; a_addr = '0; b_addr = '0; io_din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy",    32'(busy),        32'h0);
    checkOutput("rst_a_dout",  32'(a_dout),      32'hFF);
    checkOutput("rst_b_dout",  32'(b_dout),      32'hFF);
    checkOutput("rst_addr",    32'(sdram_addr),  32'h0);
    checkOutput("rst_din",     32'(sdram_din),   32'h0);
    checkOutput("rst_strobes", 32'({sdram_rd, sdram_we}), 32'h0);
    checkOutput("rst_acks",    32'({io_ack, a_ack, b_ack}), 32'h0);
    checkOutput("rst_tmo",     32'(timeout_err), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_busy", 32'(busy), 32'h0);

    // Single slot A read, ready two cycles after the strobe
    rsp_lat = 2;
    rsp_q.push_back(8'h5A);
    a_addr = 25'h0400000;
    a_req  = 1'b1;
    applyStimulus(1, 1'b0, 20);
    checkOutput("a1_rd_cnt",  32'(rd_cnt),  32'd1);
    checkOutput("a1_addr",    32'(rd_addr), 32'h0400000);
    checkOutput("a1_latency", 32'(cyc),     32'd4);
    checkOutput("a1_dout",    32'(a_dout),  32'h5A);
    checkOutput("a1_b_dout",  32'(b_dout),  32'hFF);
    @(posedge clk); #1;
    checkOutput("a1_ack_len", 32'(a_ack), 32'h0);

    // Ready during ISSUE is ignored; address changes after grant do not leak
    rsp_en = 1'b0;
    a_addr = 25'h0000123;
    a_req  = 1'b1;
    @(posedge clk); #1;
    checkOutput("man_rd",   32'(sdram_rd),   32'h1);
    checkOutput("man_addr", 32'(sdram_addr), 32'h0000123);
    sdram_ready = 1'b1; sdram_dout = 8'hEE; a_addr = 25'h1FFFFFF;
    @(posedge clk); #1;
    checkOutput("man_busy",  32'(busy),       32'h1);
    checkOutput("man_noack", 32'(a_ack),      32'h0);
    checkOutput("man_rd_1c", 32'(sdram_rd),   32'h0);
    checkOutput("man_hold",  32'(sdram_addr), 32'h0000123);
    sdram_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("man_ignored", 32'(a_dout), 32'h5A);
    sdram_ready = 1'b1; sdram_dout = 8'h5B;
    @(posedge clk); #1;
    checkOutput("man_ack",  32'(a_ack),  32'h1);
    checkOutput("man_dout", 32'(a_dout), 32'h5B);
    a_req = 1'b0; sdram_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("man_idle", 32'(busy), 32'h0);
    rsp_en = 1'b1;

    // All three request together: io, then A, then B
    applyReset();
    rsp_lat = 1;
    rsp_q.push_back(8'h21);
    rsp_q.push_back(8'h32);
    io_addr = 25'h1ABCDEF; io_din = 8'hC3;
    a_addr  = 25'h0000010; b_addr = 25'h0000020;
    io_req = 1'b1; a_req = 1'b1; b_req = 1'b1;
    applyStimulus(3, 1'b0, 40);
    checkOutput("pri_own0",  32'(log_owner[0]), 32'd0);
    checkOutput("pri_own1",  32'(log_owner[1]), 32'd1);
    checkOutput("pri_own2",  32'(log_owner[2]), 32'd2);
    checkOutput("pri_we",    32'(we_cnt),  32'd1);
    checkOutput("pri_waddr", 32'(we_addr), 32'h1ABCDEF);
    checkOutput("pri_wdin",  32'(we_din),  32'hC3);
    checkOutput("pri_rd",    32'(rd_cnt),  32'd2);
    checkOutput("pri_raddr", 32'(rd_addr), 32'h0000020);
    checkOutput("pri_a",     32'(a_dout),  32'h21);
    checkOutput("pri_b",     32'(b_dout),  32'h32);

    // A and B held continuously: strict alternation starting with A
    applyReset();
    rsp_q.push_back(8'h11); rsp_q.push_back(8'h22);
    rsp_q.push_back(8'h33); rsp_q.push_back(8'h44);
    a_addr = 25'h0000100; b_addr = 25'h0000200;
    a_req = 1'b1; b_req = 1'b1;
    applyStimulus(4, 1'b1, 60);
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_own%0d", i),  32'(log_owner[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput($sformatf("rr_data%0d", i), 32'(log_data[i]),  32'(8'h11 * (i + 1)));
    end
    checkOutput("rr_b_untouched", 32'(log_other[0]), 32'hFF);
    checkOutput("rr_a_untouched", 32'(log_other[1]), 32'h11);

    // Reset while a B read is stalled in WAIT
    @(posedge clk); #1;
    rsp_en = 1'b0;
    b_addr = 25'h0000300;
    b_req  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("rw_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rw_busy",  32'(busy),     32'h0);
    checkOutput("rw_b_dout", 32'(b_dout),  32'hFF);
    checkOutput("rw_b_ack", 32'(b_ack),    32'h0);
    checkOutput("rw_rd",    32'(sdram_rd), 32'h0);
    b_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen = seen | b_ack; end
    checkOutput("rw_no_ack", 32'(seen), 32'h0);
    rsp_en = 1'b1; rsp_lat = 1;
    rsp_q.push_back(8'h77);
    a_addr = 25'h0000042;
    a_req  = 1'b1;
    applyStimulus(1, 1'b0, 20);
    checkOutput("rw_a_latency", 32'(cyc),          32'd3);
    checkOutput("rw_a_owner",   32'(log_owner[0]), 32'd1);
    checkOutput("rw_a_addr",    32'(rd_addr),      32'h0000042);
    checkOutput("rw_a_dout",    32'(a_dout),       32'h77);

    // SDRAM never answers
    @(posedge clk); #1;
    rsp_en = 1'b0;
    b_addr = 25'h00ABCDE;
    b_req  = 1'b1;
`ifdef ARB_TIMEOUT_EN
    applyStimulus(1, 1'b0, 40);
    checkOutput("tmo_latency", 32'(cyc),         32'd10);
    checkOutput("tmo_dout",    32'(b_dout),      32'hFF);
    checkOutput("tmo_err",     32'(timeout_err), 32'h1);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("tmo_sticky",  32'(timeout_err), 32'h1);
    checkOutput("tmo_idle",    32'(busy),        32'h0);
`else
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; seen = seen | b_ack; end
    checkOutput("stall_no_ack", 32'(seen),        32'h0);
    checkOutput("stall_busy",   32'(busy),        32'h1);
    checkOutput("stall_err",    32'(timeout_err), 32'h0);
    applyReset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
